// File: rtl/mac_pkg.sv
// mac_pkg: constants shared by the MAC datapath and the divider state encoding
package mac_pkg;
    localparam int MAC_DATA_WIDTH = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, ZERO = 2'd3} div_state_t;
endpackage

// File: rtl/twos_abs_neg.sv
// twos_abs_neg: conditional two's-complement negate, used for operand magnitudes and result signs
module twos_abs_neg #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = neg_i ? -x_i : x_i;
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: restoring signed divider, one quotient bit per clock, start/done handshake
module seq_signed_divider
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] r,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);
    localparam int W = DATA_WIDTH;
    div_state_t state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0] pr_q, pr_d, dvd_q, dvd_d, q_q, q_d, r_q, r_d;
    logic [W:0] bmag_q, bmag_d, bmag, shifted;
    logic [W-1:0] amag, q_fix, r_fix, r_src;
    logic sq_q, sq_d, sr_q, sr_d, busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ge;

    // |a| fits W unsigned bits; |b| gets W+1 so the trial subtract never overflows
    twos_abs_neg #(.WIDTH(W))     u_abs_a (.x_i(a), .neg_i(a[W-1]), .y_o(amag));
    twos_abs_neg #(.WIDTH(W + 1)) u_abs_b (.x_i({b[W-1], b}), .neg_i(b[W-1]), .y_o(bmag));
    twos_abs_neg #(.WIDTH(W))     u_neg_q (.x_i(dvd_q), .neg_i(sq_q), .y_o(q_fix));
    twos_abs_neg #(.WIDTH(W))     u_neg_r (.x_i(r_src), .neg_i(sr_q), .y_o(r_fix));

    // divide-by-zero reports the dividend itself, rebuilt from its stored magnitude and sign
    assign r_src   = (state_q == ZERO) ? dvd_q : pr_q;
    assign shifted = {pr_q, dvd_q[W-1]};
    assign ge      = shifted >= bmag_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = (b == '0) ? ZERO : CALC;
                cnt_d   = '0;
                pr_d    = '0;
                dvd_d   = amag;
                bmag_d  = bmag;
                sq_d    = a[W-1] ^ b[W-1];
                sr_d    = a[W-1];
                busy_d  = 1'b1;
            end
            CALC: begin
                pr_d    = ge ? W'(shifted - bmag_q) : shifted[W-1:0];
                dvd_d   = {dvd_q[W-2:0], ge};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_WIDTH'(W - 1)) ? FIX : CALC;
            end
            FIX: begin
                state_d = IDLE;
                q_d     = q_fix;
                r_d     = r_fix;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                q_d     = '1;
                r_d     = r_fix;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dbz_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign q           = q_q;
    assign r           = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
endmodule
